// File: rtl/hwpe_flat_tcdm_bridge_pkg.sv
// Shared types and constants for the flat-port HWPE to TCDM bridge.
// The request payload struct is sized by BR_AW/BR_DW; the bridge's AW/DW
// parameters default to these and must stay equal to them.
package hwpe_flat_bridge_package;

   localparam int unsigned BR_AW         = 32;
   localparam int unsigned BR_DW         = 32;
   localparam int unsigned BR_SKID_DEPTH = 2;
   localparam int unsigned BR_STALL_W    = 32;

   // One TCDM request as it sits in the skid buffer.
   typedef struct packed {
      logic [BR_AW-1:0]   add;
      logic               wen;
      logic [BR_DW/8-1:0] be;
      logic [BR_DW-1:0]   data;
   } tcdm_req_t;

endpackage

// File: rtl/hwpe_flat_tcdm_bridge_if.sv
// Flattened multi-channel TCDM port bundle (request + response side).
// The master drives requests and consumes grants/responses; the slave is the
// opposite end.
interface hwpe_flat_tcdm_bridge_if #(
   parameter int unsigned MP = 3,
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) ();

   logic [MP-1:0]        req;
   logic [MP-1:0]        gnt;
   logic [MP*AW-1:0]     add;
   logic [MP-1:0]        wen;
   logic [MP*DW/8-1:0]   be;
   logic [MP*DW-1:0]     data;
   logic [MP*DW-1:0]     r_data;
   logic [MP-1:0]        r_valid;

   modport master (
      output req, add, wen, be, data,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt, r_data, r_valid
   );

endinterface

// File: rtl/hwpe_flat_tcdm_bridge_slice.sv
// One bridge channel: 2-entry request skid buffer with registered grant,
// outstanding-transaction credit counter, registered response stage and a
// sticky underflow flag. Optional stall statistics are built only when
// HWPE_FLAT_BRIDGE_STATS_EN is defined.
module hwpe_flat_tcdm_slice
   import hwpe_flat_bridge_package::*;
#(
   parameter int unsigned OUTST = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  engReq_i,
   output logic                  engGnt_o,
   input  tcdm_req_t             engPayload_i,
   output logic                  engRValid_o,
   output logic [BR_DW-1:0]      engRData_o,
   output logic                  tcdmReq_o,
   input  logic                  tcdmGnt_i,
   output tcdm_req_t             tcdmPayload_o,
   input  logic                  tcdmRValid_i,
   input  logic [BR_DW-1:0]      tcdmRData_i,
   output logic                  err_o,
   output logic [BR_STALL_W-1:0] stallCnt_o
);

   localparam int unsigned OW = $clog2(OUTST + 1);

   logic [1:0]       occ_q, occ_d, occAfterPop;
   logic [OW-1:0]    outst_q, outst_d;
   tcdm_req_t        slot0_q, slot0_d, slot1_q, slot1_d;
   logic             engGnt_q, engGnt_d;
   logic             err_q, err_d;
   logic             engRValid_q;
   logic [BR_DW-1:0] engRData_q;
   logic             push, pop, underflow;

   // Next-state for the skid buffer (slot0 is always the head), the credit
   // counter and the grant; grant looks only at our own next occupancy/credit.
   always_comb begin
      push        = engReq_i & engGnt_q;
      pop         = (occ_q != 2'd0) & tcdmGnt_i;
      underflow   = tcdmRValid_i & (outst_q == '0);
      occAfterPop = occ_q - {1'b0, pop};
      occ_d       = occAfterPop + {1'b0, push};
      slot0_d     = slot0_q;
      slot1_d     = slot1_q;
      if (pop && (occ_q == 2'd2)) begin
         slot0_d = slot1_q;
      end
      if (push) begin
         if (occAfterPop == 2'd0) begin
            slot0_d = engPayload_i;
         end else begin
            slot1_d = engPayload_i;
         end
      end
      outst_d  = outst_q + OW'(push) - OW'(tcdmRValid_i & ~underflow);
      err_d    = err_q | underflow;
      engGnt_d = (occ_d < 2'(BR_SKID_DEPTH)) && (outst_d < OW'(OUTST));
   end

   // Channel state registers; a reset drops anything buffered or in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ_q       <= '0;
         outst_q     <= '0;
         slot0_q     <= '0;
         slot1_q     <= '0;
         engGnt_q    <= 1'b0;
         err_q       <= 1'b0;
         engRValid_q <= 1'b0;
         engRData_q  <= '0;
      end else begin
         occ_q       <= occ_d;
         outst_q     <= outst_d;
         slot0_q     <= slot0_d;
         slot1_q     <= slot1_d;
         engGnt_q    <= engGnt_d;
         err_q       <= err_d;
         engRValid_q <= tcdmRValid_i;
         engRData_q  <= tcdmRData_i;
      end
   end

`ifdef HWPE_FLAT_BRIDGE_STATS_EN
   logic [BR_STALL_W-1:0] stallCnt_q;

   // Count cycles where the engine waits for a grant, saturating at all-ones.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stallCnt_q <= '0;
      end else if (engReq_i && !engGnt_q && (stallCnt_q != '1)) begin
         stallCnt_q <= stallCnt_q + 1'b1;
      end
   end

   assign stallCnt_o = stallCnt_q;
`else
   assign stallCnt_o = '0;
`endif

   assign engGnt_o      = engGnt_q;
   assign tcdmReq_o     = (occ_q != 2'd0);
   assign tcdmPayload_o = slot0_q;
   assign engRValid_o   = engRValid_q;
   assign engRData_o    = engRData_q;
   assign err_o         = err_q;

endmodule

// File: rtl/hwpe_flat_tcdm_bridge.sv
// Flat-port HWPE to TCDM interconnect bridge. Cuts timing in both directions
// and bounds in-flight traffic per channel; channels are independent, so the
// top only slices the flat vectors into per-channel slices.
// Optional feature macro: HWPE_FLAT_BRIDGE_STATS_EN (per-channel stall counters).
module hwpe_flat_tcdm_bridge
   import hwpe_flat_bridge_package::*;
#(
   parameter int unsigned MP    = 3,
   parameter int unsigned AW    = BR_AW,
   parameter int unsigned DW    = BR_DW,
   parameter int unsigned OUTST = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   hwpe_flat_tcdm_bridge_if.slave   eng,
   hwpe_flat_tcdm_bridge_if.master  tcdm,
   output logic [MP-1:0]            err_o,
   output logic [MP*BR_STALL_W-1:0] stall_cnt_o
);

   localparam int unsigned BW = DW / 8;

   for (genvar ch = 0; ch < MP; ch++) begin : genChannel
      tcdm_req_t engPay;
      tcdm_req_t tcdmPay;

      assign engPay = '{
         add:  eng.add[ch*AW +: AW],
         wen:  eng.wen[ch],
         be:   eng.be[ch*BW +: BW],
         data: eng.data[ch*DW +: DW]
      };

      hwpe_flat_tcdm_slice #(
         .OUTST (OUTST)
      ) uSlice (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .engReq_i      (eng.req[ch]),
         .engGnt_o      (eng.gnt[ch]),
         .engPayload_i  (engPay),
         .engRValid_o   (eng.r_valid[ch]),
         .engRData_o    (eng.r_data[ch*DW +: DW]),
         .tcdmReq_o     (tcdm.req[ch]),
         .tcdmGnt_i     (tcdm.gnt[ch]),
         .tcdmPayload_o (tcdmPay),
         .tcdmRValid_i  (tcdm.r_valid[ch]),
         .tcdmRData_i   (tcdm.r_data[ch*DW +: DW]),
         .err_o         (err_o[ch]),
         .stallCnt_o    (stall_cnt_o[ch*BR_STALL_W +: BR_STALL_W])
      );

      assign tcdm.add[ch*AW +: AW]  = tcdmPay.add;
      assign tcdm.wen[ch]           = tcdmPay.wen;
      assign tcdm.be[ch*BW +: BW]   = tcdmPay.be;
      assign tcdm.data[ch*DW +: DW] = tcdmPay.data;
   end

endmodule

// File: tb/tb_hwpe_flat_tcdm_bridge.sv
// Testbench for hwpe_flat_tcdm_bridge: the bench plays both the engine and
// the interconnect, and predicts every output from a queue-based model of
// the bridge's rules.
module tb_hwpe_flat_tcdm_bridge;
   import hwpe_flat_bridge_package::*;

   localparam int MP    = 3;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int OUTST = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [MP-1:0]    err;
   logic [MP*32-1:0] stallCnt;

   hwpe_flat_tcdm_bridge_if #(.MP(MP), .AW(AW), .DW(DW)) engIf ();
   hwpe_flat_tcdm_bridge_if #(.MP(MP), .AW(AW), .DW(DW)) tcdmIf ();

   hwpe_flat_tcdm_bridge #(.MP(MP), .AW(AW), .DW(DW), .OUTST(OUTST)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .eng         (engIf.slave),
      .tcdm        (tcdmIf.master),
      .err_o       (err),
      .stall_cnt_o (stallCnt)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Engine side stimulus state
   bit        engReq[MP];
   tcdm_req_t engPay[MP];
   int        engRemaining[MP];
   bit        engReadOnly[MP];

   // Interconnect side stimulus state
   int          gntMode[MP];
   bit          tcdmGnt[MP];
   bit          rspHold[MP];
   bit          releaseOne[MP];
   bit          injectRv[MP];
   bit          rspRandom;
   logic [31:0] icQ[MP][$];
   bit          tRv[MP];
   logic [31:0] tRd[MP];

   // Reference model
   tcdm_req_t       mFifo[MP][$];
   int              mOutst[MP];
   bit              mGnt[MP];
   bit              mErr[MP];
   longint unsigned mStall[MP];
   bit              mRv[MP];
   logic [31:0]     mRd[MP];
   bit              mAccepted[MP];

   int              dutAccepts[MP];
   int              dutRespCnt[MP];
   longint unsigned stallBase;

   function automatic logic [31:0] memResp(input tcdm_req_t p);
      return p.wen ? ((p.add ^ 32'hC0DE_0000) + 32'h11) : (p.data ^ 32'h0F0F_F0F0);
   endfunction

   task automatic check(input string tag, input int ch, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s ch%0d: observed %0h expected %0h", tag, ch, obs, exp);
      end
   endtask

   task automatic applyStimulus();
      for (int ch = 0; ch < MP; ch++) begin
         if (mAccepted[ch]) begin
            engReq[ch] = 1'b0;
            if (engRemaining[ch] > 0) engRemaining[ch]--;
         end
         if (!engReq[ch] && engRemaining[ch] > 0) begin
            engReq[ch]      = 1'b1;
            engPay[ch].add  = $urandom & 32'hFFFF_FFFC;
            engPay[ch].wen  = engReadOnly[ch] ? 1'b1 : 1'($urandom_range(0, 1));
            engPay[ch].be   = 4'($urandom);
            engPay[ch].data = $urandom;
         end
         case (gntMode[ch])
            0:       tcdmGnt[ch] = 1'b0;
            1:       tcdmGnt[ch] = 1'b1;
            default: tcdmGnt[ch] = 1'($urandom_range(0, 1));
         endcase
         tRv[ch] = 1'b0;
         tRd[ch] = '0;
         if (injectRv[ch]) begin
            tRv[ch]      = 1'b1;
            tRd[ch]      = $urandom;
            injectRv[ch] = 1'b0;
         end else if (icQ[ch].size() != 0 && (!rspHold[ch] || releaseOne[ch])
                      && !(rspRandom && $urandom_range(0, 3) == 0)) begin
            tRv[ch]        = 1'b1;
            tRd[ch]        = icQ[ch].pop_front();
            releaseOne[ch] = 1'b0;
         end
         engIf.req[ch]             = engReq[ch];
         engIf.add[ch*AW +: AW]    = engPay[ch].add;
         engIf.wen[ch]             = engPay[ch].wen;
         engIf.be[ch*BW +: BW]     = engPay[ch].be;
         engIf.data[ch*DW +: DW]   = engPay[ch].data;
         tcdmIf.gnt[ch]            = tcdmGnt[ch];
         tcdmIf.r_valid[ch]        = tRv[ch];
         tcdmIf.r_data[ch*DW +: DW] = tRd[ch];
      end
   endtask

   task automatic checkOutput();
      for (int ch = 0; ch < MP; ch++) begin
         check("eng_gnt", ch, 64'(engIf.gnt[ch]), 64'(mGnt[ch]));
         check("tcdm_req", ch, 64'(tcdmIf.req[ch]), 64'(mFifo[ch].size() != 0));
         if (mFifo[ch].size() != 0) begin
            check("tcdm_add", ch, 64'(tcdmIf.add[ch*AW +: AW]), 64'(mFifo[ch][0].add));
            check("tcdm_wen", ch, 64'(tcdmIf.wen[ch]), 64'(mFifo[ch][0].wen));
            check("tcdm_be", ch, 64'(tcdmIf.be[ch*BW +: BW]), 64'(mFifo[ch][0].be));
            check("tcdm_data", ch, 64'(tcdmIf.data[ch*DW +: DW]), 64'(mFifo[ch][0].data));
         end
         check("eng_r_valid", ch, 64'(engIf.r_valid[ch]), 64'(mRv[ch]));
         check("eng_r_data", ch, 64'(engIf.r_data[ch*DW +: DW]), 64'(mRd[ch]));
         check("err", ch, 64'(err[ch]), 64'(mErr[ch]));
`ifdef HWPE_FLAT_BRIDGE_STATS_EN
         check("stall_cnt", ch, 64'(stallCnt[ch*32 +: 32]), mStall[ch]);
`else
         check("stall_cnt", ch, 64'(stallCnt[ch*32 +: 32]), 64'd0);
`endif
         if (engReq[ch] && engIf.gnt[ch] === 1'b1) dutAccepts[ch]++;
         if (engIf.r_valid[ch] === 1'b1) dutRespCnt[ch]++;
      end
   endtask

   task automatic checkResetZero();
      for (int ch = 0; ch < MP; ch++) begin
         check("rst_tcdm_add", ch, 64'(tcdmIf.add[ch*AW +: AW]), 64'd0);
         check("rst_tcdm_wen", ch, 64'(tcdmIf.wen[ch]), 64'd0);
         check("rst_tcdm_be", ch, 64'(tcdmIf.be[ch*BW +: BW]), 64'd0);
         check("rst_tcdm_data", ch, 64'(tcdmIf.data[ch*DW +: DW]), 64'd0);
      end
   endtask

   // Advance the model by one clock edge using this cycle's inputs.
   task automatic modelStep();
      for (int ch = 0; ch < MP; ch++) mAccepted[ch] = 1'b0;
      if (rst) begin
         for (int ch = 0; ch < MP; ch++) begin
            mFifo[ch].delete();
            mOutst[ch] = 0;
            mGnt[ch]   = 1'b0;
            mErr[ch]   = 1'b0;
            mStall[ch] = 0;
            mRv[ch]    = 1'b0;
            mRd[ch]    = '0;
         end
      end else begin
         for (int ch = 0; ch < MP; ch++) begin
            bit push;
            bit pop;
            push = engReq[ch] && mGnt[ch];
            pop  = (mFifo[ch].size() != 0) && tcdmGnt[ch];
            if (pop) icQ[ch].push_back(memResp(mFifo[ch].pop_front()));
            if (push) begin
               mFifo[ch].push_back(engPay[ch]);
               mAccepted[ch] = 1'b1;
            end
            if (tRv[ch]) begin
               if (mOutst[ch] > 0) mOutst[ch]--;
               else mErr[ch] = 1'b1;
            end
            if (push) mOutst[ch]++;
            if (engReq[ch] && !mGnt[ch] && mStall[ch] != 64'hFFFF_FFFF) mStall[ch]++;
            mGnt[ch] = (mFifo[ch].size() < 2) && (mOutst[ch] < OUTST);
            mRv[ch]  = tRv[ch];
            mRd[ch]  = tRd[ch];
         end
      end
   endtask

   task automatic cycle();
      applyStimulus();
      checkOutput();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   initial begin
      rspRandom = 1'b0;
      for (int ch = 0; ch < MP; ch++) begin
         engReq[ch]       = 1'b0;
         engPay[ch]       = '0;
         engRemaining[ch] = 1;
         engReadOnly[ch]  = 1'b1;
         gntMode[ch]      = 1;
         rspHold[ch]      = 1'b0;
         releaseOne[ch]   = 1'b0;
         injectRv[ch]     = 1'b0;
         mAccepted[ch]    = 1'b0;
         dutAccepts[ch]   = 0;
         dutRespCnt[ch]   = 0;
      end

      // Reset held for three edges with the engines already requesting
      rst = 1'b1;
      applyStimulus();
      @(posedge clk);
      modelStep();
      #1;
      checkResetZero();
      cycle();
      checkResetZero();
      cycle();
      checkResetZero();
      rst = 1'b0;
      cycle();
      check("gnt_after_reset", 0, 64'(engIf.gnt), 64'(3'b111));
      repeat (6) cycle();

      // Streaming reads on channel 0
      dutAccepts[0] = 0;
      dutRespCnt[0] = 0;
      engRemaining[0] = 16;
      repeat (16) cycle();
      check("stream_accepts", 0, 64'(dutAccepts[0]), 64'd16);
      repeat (5) cycle();
      check("stream_responses", 0, 64'(dutRespCnt[0]), 64'd16);

      // Credit limit on channel 2 with responses withheld
      rspHold[2]      = 1'b1;
      dutAccepts[2]   = 0;
      engRemaining[2] = 6;
      repeat (8) cycle();
      check("credit_accepts", 2, 64'(dutAccepts[2]), 64'd4);
      check("credit_gnt_low", 2, 64'(engIf.gnt[2]), 64'd0);
      releaseOne[2] = 1'b1;
      repeat (4) cycle();
      check("credit_one_more", 2, 64'(dutAccepts[2]), 64'd5);
      rspHold[2] = 1'b0;
      repeat (12) cycle();

      // Interconnect backpressure on channel 1
      gntMode[1]      = 0;
      dutAccepts[1]   = 0;
      engRemaining[1] = 5;
      repeat (10) cycle();
      check("bp_accepts", 1, 64'(dutAccepts[1]), 64'd2);
      check("bp_gnt_low", 1, 64'(engIf.gnt[1]), 64'd0);
      gntMode[1] = 1;
      repeat (15) cycle();
      check("bp_drained", 1, 64'(dutAccepts[1]), 64'd5);

      // Response underflow on channel 1
      repeat (5) cycle();
      injectRv[1] = 1'b1;
      cycle();
      check("underflow_err1", 1, 64'(err[1]), 64'd1);
      check("underflow_err0", 0, 64'(err[0]), 64'd0);
      check("underflow_fwd", 1, 64'(engIf.r_valid[1]), 64'd1);
      repeat (3) cycle();

      // Stall statistics on channel 0: two accepts, then seven blocked cycles
      stallBase       = mStall[0];
      gntMode[0]      = 0;
      engRemaining[0] = 3;
      repeat (9) cycle();
`ifdef HWPE_FLAT_BRIDGE_STATS_EN
      check("stall_seven", 0, 64'(stallCnt[31:0]), stallBase + 7);
`else
      check("stall_off", 0, 64'(stallCnt), 64'd0);
`endif
      gntMode[0] = 1;
      repeat (8) cycle();

      // Randomised traffic on all channels, with a reset in the middle
      rspRandom = 1'b1;
      for (int ch = 0; ch < MP; ch++) begin
         gntMode[ch]      = 2;
         engReadOnly[ch]  = 1'b0;
         engRemaining[ch] = 40;
      end
      repeat (150) cycle();
      rst = 1'b1;
      repeat (2) cycle();
      rst = 1'b0;
      repeat (60) cycle();
      rspRandom = 1'b0;
      for (int ch = 0; ch < MP; ch++) begin
         gntMode[ch]      = 1;
         engRemaining[ch] = 0;
      end
      repeat (20) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
